// File: rtl/dsp_simd_pkg.sv
// Shared types for the three-lane SIMD gather/scatter wrapper around the packed DSP logic op.
package dsp_simd_pkg;
  localparam int LANES  = 3;
  localparam int LANE_W = 12;

  typedef enum logic [1:0] {
    GATHER  = 2'd0,
    ISSUE   = 2'd1,
    SCATTER = 2'd2
  } simd_state_t;

  typedef struct packed {
    logic [LANE_W-1:0] a;
    logic [LANE_W-1:0] b;
  } lane_t;
endpackage

// File: rtl/dsp_simd3_gather.sv
// Gathers up to three scalar operand pairs into DSP lanes, holds them for the op's latency,
// then scatters the captured lane results back out as a scalar stream in arrival order.
module dsp_simd3_gather
  import dsp_simd_pkg::*;
#(
  parameter int width      = 12,
  parameter int op_latency = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] in_a,
  input  logic [width-1:0] in_b,
  input  logic             in_last,
  output logic [width-1:0] op_a0,
  output logic [width-1:0] op_b0,
  output logic [width-1:0] op_a1,
  output logic [width-1:0] op_b1,
  output logic [width-1:0] op_a2,
  output logic [width-1:0] op_b2,
  input  logic [width-1:0] op_y0,
  input  logic [width-1:0] op_y1,
  input  logic [width-1:0] op_y2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] out_y,
  output logic             out_last
);

  if (width < 1 || width > LANE_W) begin : g_bad_width
    $error("dsp_simd3_gather: width must be 1..12");
  end
  if (op_latency < 0 || op_latency > 2) begin : g_bad_latency
    $error("dsp_simd3_gather: op_latency must be 0..2");
  end

  simd_state_t       state;
  lane_t             lanes [LANES];
  logic [LANE_W-1:0] res   [LANES];
  logic [1:0]        cnt, n, idx, lat_cnt;
  logic              last_flag;
  logic              accept;

  assign accept    = in_valid && in_ready;
  assign in_ready  = reset && (state == GATHER);
  assign out_valid = (state == SCATTER);
  assign out_y     = out_valid ? res[idx][width-1:0] : '0;
  assign out_last  = out_valid && last_flag && (idx == n - 2'd1);

  // Lane registers feed the DSP op continuously; unfilled lanes sit at zero.
  assign op_a0 = lanes[0].a[width-1:0];
  assign op_b0 = lanes[0].b[width-1:0];
  assign op_a1 = lanes[1].a[width-1:0];
  assign op_b1 = lanes[1].b[width-1:0];
  assign op_a2 = lanes[2].a[width-1:0];
  assign op_b2 = lanes[2].b[width-1:0];

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= GATHER;
      cnt       <= '0;
      n         <= '0;
      idx       <= '0;
      lat_cnt   <= '0;
      last_flag <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        lanes[i] <= '0;
        res[i]   <= '0;
      end
    end else begin
      case (state)
        GATHER: if (accept) begin
          lanes[cnt] <= '{a: LANE_W'(in_a), b: LANE_W'(in_b)};
          cnt        <= cnt + 2'd1;
          if (cnt == 2'd2 || in_last) begin
            state     <= ISSUE;
            n         <= cnt + 2'd1;
            last_flag <= in_last;
            lat_cnt   <= '0;
          end
        end
        // Lanes stay frozen until the op's pipeline has produced results for them.
        ISSUE: if (lat_cnt == 2'(op_latency)) begin
          res[0] <= LANE_W'(op_y0);
          res[1] <= LANE_W'(op_y1);
          res[2] <= LANE_W'(op_y2);
          idx    <= '0;
          state  <= SCATTER;
        end else begin
          lat_cnt <= lat_cnt + 2'd1;
        end
        SCATTER: if (out_ready) begin
          if (idx == n - 2'd1) begin
            state     <= GATHER;
            cnt       <= '0;
            last_flag <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
              lanes[i] <= '0;
              res[i]   <= '0;
            end
          end else begin
            idx <= idx + 2'd1;
          end
        end
        default: state <= GATHER;
      endcase
    end
  end

endmodule

// File: tb/tb_dsp_simd3_gather.sv
// Bench for dsp_simd3_gather: three configurations (12b/lat0, 12b/lat2, 8b/lat0), each with an
// OR op model, directed bundles, reset/backpressure cases and random traffic against a scoreboard.
module tb_dsp_simd3_gather;
  logic clock = 1'b0;
  initial forever #5 clock = ~clock;

  int errors = 0, checks = 0, done_cnt = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int W   = (g == 2) ? 8 : 12;
    localparam int LAT = (g == 1) ? 2 : 0;

    logic rst_n = 1'b0, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
    logic in_ready, out_valid, out_last;
    logic [W-1:0] in_a = '0, in_b = '0, out_y;
    logic [W-1:0] op_a0, op_b0, op_a1, op_b1, op_a2, op_b2, op_y0, op_y1, op_y2;
    logic [3*W-1:0] y_now;
    logic [3*W-1:0] dly [3];
    int cyc = 0, rdy_mode = 0, acc_cyc = 0, out_cyc = 0;
    logic [W:0]     exq [$];
    logic [2*W-1:0] grp [$];

    dsp_simd3_gather #(.width(W), .op_latency(LAT)) dut (
      .clock(clock), .reset(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_last(in_last),
      .op_a0(op_a0), .op_b0(op_b0), .op_a1(op_a1), .op_b1(op_b1), .op_a2(op_a2), .op_b2(op_b2),
      .op_y0(op_y0), .op_y1(op_y1), .op_y2(op_y2),
      .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_last(out_last)
    );

    // OR DSP op with LAT register stages
    assign y_now = {op_a2 | op_b2, op_a1 | op_b1, op_a0 | op_b0};
    always @(posedge clock) begin
      dly[0] <= y_now;
      dly[1] <= dly[0];
      dly[2] <= dly[1];
      cyc    <= cyc + 1;
    end
    assign {op_y2, op_y1, op_y0} = (LAT == 0) ? y_now : dly[(LAT == 0) ? 0 : LAT - 1];

    function automatic string nm(string s);
      return $sformatf("c%0d.%s", g, s);
    endfunction

    initial forever begin
      @(posedge clock); #2;
      out_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b0;
    end

    initial forever begin
      logic [W:0] e;
      @(negedge clock);
      if (rst_n && out_valid && out_ready) begin
        out_cyc = cyc;
        chk(nm("result_expected"), 32'(exq.size() != 0), 1);
        if (exq.size() != 0) begin
          e = exq.pop_front();
          chk(nm("out_y"), 32'(out_y), 32'(e[W-1:0]));
          chk(nm("out_last"), 32'(out_last), 32'(e[W]));
        end
      end
    end

    task automatic tick();
      @(posedge clock); #1;
    endtask

    // Reference: groups close at three pairs or on last; each result is a|b in arrival order.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic l);
      logic acc = 1'b0;
      int t = 0;
      in_valid = 1'b1; in_a = a; in_b = b; in_last = l;
      while (!acc && t < 300) begin
        @(negedge clock);
        acc = in_ready;
        acc_cyc = cyc;
        tick();
        t++;
      end
      chk(nm("accept_in_time"), 32'(acc), 1);
      in_valid = 1'b0; in_a = W'($urandom); in_b = W'($urandom); in_last = 1'($urandom);
      if (acc) begin
        grp.push_back({a, b});
        if (grp.size() == 3 || l) begin
          for (int i = 0; i < grp.size(); i++)
            exq.push_back({l && (i == grp.size() - 1), grp[i][2*W-1:W] | grp[i][W-1:0]});
          grp.delete();
        end
      end
    endtask

    task automatic drain();
      int t = 0;
      while (exq.size() != 0 && t < 500) begin
        tick();
        t++;
      end
      chk(nm("drain"), 32'(exq.size()), 0);
      tick();
    endtask

    initial begin
      int first;
      logic [W-1:0] pa [3];
      logic [W-1:0] pb [3];
      pa = '{W'(12'h0F0), W'(12'hA00), W'(12'h001)};
      pb = '{W'(12'h00F), W'(12'h050), W'(12'h800)};

      repeat (2) tick();
      @(negedge clock);
      chk(nm("rst_in_ready"), 32'(in_ready), 0);
      chk(nm("rst_out_valid"), 32'(out_valid), 0);
      chk(nm("rst_out_y"), 32'(out_y), 0);
      chk(nm("rst_out_last"), 32'(out_last), 0);
      chk(nm("rst_op_a0"), 32'(op_a0), 0);
      tick();
      rst_n = 1'b1;
      tick();

      // full bundle, lanes frozen over the issue window, end-to-end cycle count
      first = 0;
      for (int i = 0; i < 3; i++) begin
        send(pa[i], pb[i], i == 2);
        if (i == 0) first = acc_cyc;
      end
      for (int k = 0; k <= LAT; k++) begin
        @(negedge clock);
        chk(nm("issue_out_valid"), 32'(out_valid), 0);
        chk(nm("issue_in_ready"), 32'(in_ready), 0);
        chk(nm("issue_op_a0"), 32'(op_a0), 32'(pa[0]));
        chk(nm("issue_op_b2"), 32'(op_b2), 32'(pb[2]));
        tick();
      end
      @(negedge clock);
      chk(nm("scatter_out_valid"), 32'(out_valid), 1);
      tick();
      drain();
      chk(nm("bundle_cycles"), 32'(out_cyc - first + 1), 32'(7 + LAT));

      // partial bundle: unfilled lanes stay zero, single result
      send(W'(12'h123), W'(12'h404), 1'b1);
      @(negedge clock);
      chk(nm("part_op_a0"), 32'(op_a0), 32'(W'(12'h123)));
      chk(nm("part_op_a1"), 32'(op_a1), 0);
      chk(nm("part_op_b1"), 32'(op_b1), 0);
      chk(nm("part_op_a2"), 32'(op_a2), 0);
      chk(nm("part_op_b2"), 32'(op_b2), 0);
      tick();
      drain();
      @(negedge clock);
      chk(nm("part_back_gather"), 32'(in_ready), 1);
      tick();

      // backpressure on the second result
      for (int i = 0; i < 3; i++) send(pa[i], pb[i], i == 2);
      repeat (LAT + 2) tick();
      rdy_mode = 2;
      repeat (4) begin
        @(negedge clock);
        chk(nm("bp_out_valid"), 32'(out_valid), 1);
        chk(nm("bp_out_y"), 32'(out_y), 32'(pa[1] | pb[1]));
        chk(nm("bp_in_ready"), 32'(in_ready), 0);
        tick();
      end
      rdy_mode = 0;
      drain();

      // reset after the first result drops the rest of the bundle
      for (int i = 0; i < 3; i++) send(W'($urandom), W'($urandom), i == 2);
      repeat (LAT + 2) tick();
      rst_n = 1'b0;
      exq.delete();
      grp.delete();
      @(negedge clock);
      chk(nm("rstmid_in_ready_low"), 32'(in_ready), 0);
      tick();
      rst_n = 1'b1;
      @(negedge clock);
      chk(nm("rstmid_out_valid"), 32'(out_valid), 0);
      chk(nm("rstmid_out_y"), 32'(out_y), 0);
      chk(nm("rstmid_out_last"), 32'(out_last), 0);
      chk(nm("rstmid_in_ready"), 32'(in_ready), 1);
      tick();
      send(W'($urandom), W'($urandom), 1'b0);
      send(W'($urandom), W'($urandom), 1'b1);
      drain();

      // random traffic with random backpressure and group lengths
      rdy_mode = 1;
      repeat (60) begin
        repeat ($urandom_range(0, 2)) tick();
        send(W'($urandom), W'($urandom), $urandom_range(0, 3) == 0);
      end
      send(W'($urandom), W'($urandom), 1'b1);
      drain();
      done_cnt++;
    end
  end

  initial begin
    int t = 0;
    while (done_cnt < 3 && t < 20000) begin
      @(posedge clock);
      t++;
    end
    chk("all_configs_done", 32'(done_cnt), 3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
